// File: rtl/regfile_param.sv
// Parametrised register file: one write port, one or two registered read ports,
// optional hardwired-zero entry 0, write-first bypass and a post-reset clear sweep.
module regfile_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   parameter int NUM_RD   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              readEn,
   input  logic              writeEn,
   input  logic [ADDR_W-1:0] rd,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   input  logic [DATA_W-1:0] dataIn,
   output logic [DATA_W-1:0] readOut1,
   output logic [DATA_W-1:0] readOut2,
   output logic              busy,
   output logic              state_dbg
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   ptr;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic                sweep_we;
   logic                active;
   logic                wr_drop;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_wa;
   logic [DATA_W-1:0]   mem_wd;
   logic [DATA_W-1:0]   val1;
   logic [DATA_W-1:0]   val2;

   assign busy      = (state == CLEAR) || reset;
   assign state_dbg = (state == READY);

   assign sweep_we = en && !reset && (state == CLEAR);
   assign active   = en && !reset && (state == READY);
   assign wr_drop  = (ZERO_REG != 0) && (rd == '0);

   // The sweep and the user write share the single memory write port.
   assign mem_we = sweep_we || (active && writeEn && !wr_drop);
   assign mem_wa = sweep_we ? ptr : rd;
   assign mem_wd = sweep_we ? '0 : dataIn;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= CLEAR;
         ptr   <= '0;
      end else if (en && state == CLEAR) begin
         ptr <= ptr + 1'b1;
         if (&ptr) begin
            state <= READY;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_wa] <= mem_wd;
      end
   end

   // Zero check comes first so a dropped write to entry 0 is never forwarded.
   always_comb begin
      val1 = mem[rs1];
      if (ZERO_REG != 0 && rs1 == '0) begin
         val1 = '0;
      end else if (BYPASS != 0 && writeEn && rd == rs1) begin
         val1 = dataIn;
      end
   end

   always_comb begin
      val2 = mem[rs2];
      if (ZERO_REG != 0 && rs2 == '0) begin
         val2 = '0;
      end else if (BYPASS != 0 && writeEn && rd == rs2) begin
         val2 = dataIn;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         readOut1 <= '0;
      end else if (active && readEn) begin
         readOut1 <= val1;
      end
   end

   generate
      if (NUM_RD >= 2) begin : g_rd2
         always_ff @(posedge clk) begin
            if (reset) begin
               readOut2 <= '0;
            end else if (active && readEn) begin
               readOut2 <= val2;
            end
         end
      end else begin : g_rd1
         logic unused_rd2;
         assign unused_rd2 = ^val2;
         assign readOut2   = '0;
      end
   endgenerate

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: directed scenarios on a default and a no-bypass/no-zero
// instance, plus a randomized run of a narrow single-read-port instance against a model.
module tb_regfile_param;

   logic        clk = 1'b0;
   logic        reset, en, readEn, writeEn;
   logic [4:0]  rd, rs1, rs2;
   logic [31:0] dataIn;
   logic [31:0] ro1, ro2, nb_ro1, nb_ro2;
   logic        busy, nb_busy, st, nb_st;

   logic        s_reset, s_en, s_readEn, s_writeEn;
   logic [2:0]  s_rd, s_rs1, s_rs2;
   logic [15:0] s_data, s_ro1, s_ro2;
   logic        s_busy, s_st;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   regfile_param u_dut (
      .clk(clk), .reset(reset), .en(en), .readEn(readEn), .writeEn(writeEn),
      .rd(rd), .rs1(rs1), .rs2(rs2), .dataIn(dataIn),
      .readOut1(ro1), .readOut2(ro2), .busy(busy), .state_dbg(st)
   );

   regfile_param #(.ZERO_REG(0), .BYPASS(0)) u_nb (
      .clk(clk), .reset(reset), .en(en), .readEn(readEn), .writeEn(writeEn),
      .rd(rd), .rs1(rs1), .rs2(rs2), .dataIn(dataIn),
      .readOut1(nb_ro1), .readOut2(nb_ro2), .busy(nb_busy), .state_dbg(nb_st)
   );

   regfile_param #(.DATA_W(16), .ADDR_W(3), .NUM_RD(1)) u_small (
      .clk(clk), .reset(s_reset), .en(s_en), .readEn(s_readEn), .writeEn(s_writeEn),
      .rd(s_rd), .rs1(s_rs1), .rs2(s_rs2), .dataIn(s_data),
      .readOut1(s_ro1), .readOut2(s_ro2), .busy(s_busy), .state_dbg(s_st)
   );

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      int cnt, cnt_nb, guard;
      reset = 1'b1; en = 1'b1; readEn = 1'b0; writeEn = 1'b0;
      cyc(3);
      n_vec++; if (ro1 !== 32'h0) begin n_miss++; $display("FAIL reset_ro1: got %h expected 0", ro1); end
      n_vec++; if (ro2 !== 32'h0) begin n_miss++; $display("FAIL reset_ro2: got %h expected 0", ro2); end
      n_vec++; if (busy !== 1'b1) begin n_miss++; $display("FAIL reset_busy: got %b expected 1", busy); end
      reset = 1'b0;
      cnt = 0; cnt_nb = 0; guard = 0;
      while ((busy || nb_busy) && guard < 200) begin
         if (busy) cnt++;
         if (nb_busy) cnt_nb++;
         guard++;
         @(negedge clk);
      end
      n_vec++; if (cnt != 32) begin n_miss++; $display("FAIL sweep_len: got %0d expected 32", cnt); end
      n_vec++; if (cnt_nb != 32) begin n_miss++; $display("FAIL sweep_len_nb: got %0d expected 32", cnt_nb); end
      readEn = 1'b1;
      for (int i = 0; i < 32; i++) begin
         rs1 = 5'(i); rs2 = 5'(31 - i);
         @(negedge clk);
         n_vec++; if (ro1 !== 32'h0) begin n_miss++; $display("FAIL clear_rd1[%0d]: got %h expected 0", i, ro1); end
         n_vec++; if (ro2 !== 32'h0) begin n_miss++; $display("FAIL clear_rd2[%0d]: got %h expected 0", 31 - i, ro2); end
         n_vec++; if (nb_ro1 !== 32'h0) begin n_miss++; $display("FAIL clear_nb[%0d]: got %h expected 0", i, nb_ro1); end
      end
      readEn = 1'b0;
      // restart mid-sweep after 10 sweep edges
      reset = 1'b1; cyc(1); reset = 1'b0; cyc(10);
      reset = 1'b1; cyc(1); reset = 1'b0;
      cnt = 0; guard = 0;
      while (busy && guard < 200) begin
         cnt++; guard++;
         @(negedge clk);
      end
      n_vec++; if (cnt != 32) begin n_miss++; $display("FAIL restart_len: got %0d expected 32", cnt); end
   endtask

   task automatic test_write_read;
      writeEn = 1'b1; rd = 5'd5; dataIn = 32'hDEADBEEF; readEn = 1'b0;
      cyc(1);
      writeEn = 1'b0; readEn = 1'b1; rs1 = 5'd5; rs2 = 5'd5;
      cyc(1);
      n_vec++; if (ro1 !== 32'hDEADBEEF) begin n_miss++; $display("FAIL wr_rd_ro1: got %h expected deadbeef", ro1); end
      n_vec++; if (ro2 !== 32'hDEADBEEF) begin n_miss++; $display("FAIL wr_rd_ro2: got %h expected deadbeef", ro2); end
      n_vec++; if (nb_ro1 !== 32'hDEADBEEF) begin n_miss++; $display("FAIL wr_rd_nb: got %h expected deadbeef", nb_ro1); end
      readEn = 1'b0; writeEn = 1'b1; dataIn = 32'h1;
      cyc(1);
      n_vec++; if (ro1 !== 32'hDEADBEEF) begin n_miss++; $display("FAIL hold_ro1: got %h expected deadbeef", ro1); end
      n_vec++; if (ro2 !== 32'hDEADBEEF) begin n_miss++; $display("FAIL hold_ro2: got %h expected deadbeef", ro2); end
      writeEn = 1'b0; readEn = 1'b1;
      cyc(1);
      n_vec++; if (ro1 !== 32'h1) begin n_miss++; $display("FAIL reread_ro1: got %h expected 1", ro1); end
   endtask

   task automatic test_bypass;
      readEn = 1'b0; writeEn = 1'b1;
      rd = 5'd7; dataIn = 32'h11111111; cyc(1);
      rd = 5'd6; dataIn = 32'h66666666; cyc(1);
      rd = 5'd7; dataIn = 32'h22222222; readEn = 1'b1; rs1 = 5'd7; rs2 = 5'd6;
      cyc(1);
      n_vec++; if (ro1 !== 32'h22222222) begin n_miss++; $display("FAIL byp_ro1: got %h expected 22222222", ro1); end
      n_vec++; if (ro2 !== 32'h66666666) begin n_miss++; $display("FAIL byp_ro2: got %h expected 66666666", ro2); end
      n_vec++; if (nb_ro1 !== 32'h11111111) begin n_miss++; $display("FAIL nobyp_ro1: got %h expected 11111111", nb_ro1); end
      n_vec++; if (nb_ro2 !== 32'h66666666) begin n_miss++; $display("FAIL nobyp_ro2: got %h expected 66666666", nb_ro2); end
      writeEn = 1'b0; rs2 = 5'd7;
      cyc(1);
      n_vec++; if (nb_ro1 !== 32'h22222222) begin n_miss++; $display("FAIL nobyp_later: got %h expected 22222222", nb_ro1); end
      n_vec++; if (ro2 !== 32'h22222222) begin n_miss++; $display("FAIL byp_later: got %h expected 22222222", ro2); end
      writeEn = 1'b1; rd = 5'd9; dataIn = 32'h99999999; rs1 = 5'd9; rs2 = 5'd9;
      cyc(1);
      n_vec++; if (ro1 !== 32'h99999999) begin n_miss++; $display("FAIL dual_byp1: got %h expected 99999999", ro1); end
      n_vec++; if (ro2 !== 32'h99999999) begin n_miss++; $display("FAIL dual_byp2: got %h expected 99999999", ro2); end
      n_vec++; if (nb_ro2 !== 32'h0) begin n_miss++; $display("FAIL dual_nobyp: got %h expected 0", nb_ro2); end
      writeEn = 1'b0;
   endtask

   task automatic test_zero_reg;
      writeEn = 1'b1; rd = 5'd0; dataIn = 32'hFFFFFFFF; readEn = 1'b1; rs1 = 5'd0; rs2 = 5'd0;
      cyc(1);
      n_vec++; if (ro1 !== 32'h0) begin n_miss++; $display("FAIL zero_same: got %h expected 0", ro1); end
      n_vec++; if (nb_ro1 !== 32'h0) begin n_miss++; $display("FAIL zero_nb_same: got %h expected 0", nb_ro1); end
      writeEn = 1'b0;
      cyc(1);
      n_vec++; if (ro1 !== 32'h0) begin n_miss++; $display("FAIL zero_later: got %h expected 0", ro1); end
      n_vec++; if (ro2 !== 32'h0) begin n_miss++; $display("FAIL zero_later2: got %h expected 0", ro2); end
      n_vec++; if (nb_ro1 !== 32'hFFFFFFFF) begin n_miss++; $display("FAIL zero_nb_later: got %h expected ffffffff", nb_ro1); end
   endtask

   task automatic test_enable;
      int cnt, cnt_nb, guard;
      en = 1'b0; writeEn = 1'b1; rd = 5'd31; dataIn = 32'hA5A5A5A5; readEn = 1'b1; rs1 = 5'd31; rs2 = 5'd31;
      cyc(1);
      n_vec++; if (ro1 !== 32'h0) begin n_miss++; $display("FAIL en0_hold: got %h expected 0", ro1); end
      n_vec++; if (nb_ro1 !== 32'hFFFFFFFF) begin n_miss++; $display("FAIL en0_hold_nb: got %h expected ffffffff", nb_ro1); end
      en = 1'b1; writeEn = 1'b0;
      cyc(1);
      n_vec++; if (ro1 !== 32'h0) begin n_miss++; $display("FAIL en0_nowrite: got %h expected 0", ro1); end
      n_vec++; if (nb_ro1 !== 32'h0) begin n_miss++; $display("FAIL en0_nowrite_nb: got %h expected 0", nb_ro1); end
      writeEn = 1'b1; readEn = 1'b0;
      cyc(1);
      writeEn = 1'b0; readEn = 1'b1;
      cyc(1);
      n_vec++; if (ro1 !== 32'hA5A5A5A5) begin n_miss++; $display("FAIL top_ro1: got %h expected a5a5a5a5", ro1); end
      n_vec++; if (ro2 !== 32'hA5A5A5A5) begin n_miss++; $display("FAIL top_ro2: got %h expected a5a5a5a5", ro2); end
      // accesses during the sweep must be ignored
      writeEn = 1'b1; rd = 5'd3; dataIn = 32'h33333333; rs2 = 5'd3;
      reset = 1'b1; cyc(1); reset = 1'b0;
      n_vec++; if (ro1 !== 32'h0) begin n_miss++; $display("FAIL reset_clr_ro1: got %h expected 0", ro1); end
      cnt = 0; cnt_nb = 0; guard = 0;
      while ((busy || nb_busy) && guard < 200) begin
         if (busy) cnt++;
         if (nb_busy) cnt_nb++;
         n_vec++; if (ro2 !== 32'h0) begin n_miss++; $display("FAIL busy_ro2[%0d]: got %h expected 0", guard, ro2); end
         en = !(guard >= 10 && guard < 14);
         guard++;
         @(negedge clk);
      end
      en = 1'b1;
      n_vec++; if (cnt != 36) begin n_miss++; $display("FAIL en_pause_len: got %0d expected 36", cnt); end
      n_vec++; if (cnt_nb != 36) begin n_miss++; $display("FAIL en_pause_len_nb: got %0d expected 36", cnt_nb); end
      writeEn = 1'b0; rs1 = 5'd3; rs2 = 5'd31;
      cyc(1);
      n_vec++; if (ro1 !== 32'h0) begin n_miss++; $display("FAIL busy_nowrite: got %h expected 0", ro1); end
      n_vec++; if (ro2 !== 32'h0) begin n_miss++; $display("FAIL resweep_top: got %h expected 0", ro2); end
      readEn = 1'b0;
   endtask

   task automatic test_random;
      logic [15:0] mm [8];
      int          clr_left;
      logic [15:0] e1, v;
      logic        exp_busy;
      for (int i = 0; i < 8; i++) mm[i] = 16'h0;
      clr_left = 8;
      e1 = 16'h0;
      for (int c = 0; c < 1000; c++) begin
         s_reset   = ($urandom_range(0, 199) == 0);
         s_en      = ($urandom_range(0, 9) != 0);
         s_readEn  = ($urandom_range(0, 9) < 7);
         s_writeEn = ($urandom_range(0, 1) == 1);
         s_rd      = 3'($urandom_range(0, 7));
         s_rs1     = 3'($urandom_range(0, 7));
         s_rs2     = 3'($urandom_range(0, 7));
         s_data    = 16'($urandom);
         #1;
         exp_busy = s_reset || (clr_left > 0);
         n_vec++; if (s_busy !== exp_busy) begin n_miss++; $display("FAIL rnd_busy[%0d]: got %b expected %b", c, s_busy, exp_busy); end
         if (s_reset) begin
            clr_left = 8;
            e1 = 16'h0;
         end else if (s_en) begin
            if (clr_left > 0) begin
               mm[8 - clr_left] = 16'h0;
               clr_left--;
            end else begin
               if (s_rs1 == 3'd0) v = 16'h0;
               else if (s_writeEn && s_rd == s_rs1) v = s_data;
               else v = mm[s_rs1];
               if (s_readEn) e1 = v;
               if (s_writeEn && s_rd != 3'd0) mm[s_rd] = s_data;
            end
         end
         @(negedge clk);
         n_vec++; if (s_ro1 !== e1) begin n_miss++; $display("FAIL rnd_ro1[%0d]: got %h expected %h", c, s_ro1, e1); end
         n_vec++; if (s_ro2 !== 16'h0) begin n_miss++; $display("FAIL rnd_ro2[%0d]: got %h expected 0", c, s_ro2); end
      end
   endtask

   initial begin
      reset = 1'b1; en = 1'b1; readEn = 1'b0; writeEn = 1'b0;
      rd = '0; rs1 = '0; rs2 = '0; dataIn = '0;
      s_reset = 1'b1; s_en = 1'b1; s_readEn = 1'b0; s_writeEn = 1'b0;
      s_rd = '0; s_rs1 = '0; s_rs2 = '0; s_data = '0;
      @(negedge clk);
      test_reset;
      test_write_read;
      test_bypass;
      test_zero_reg;
      test_enable;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
Parametrised successor to the CPU register file. It provides a configurable width and depth storage array with one write port and NUM_RD read ports (1 or 2). Reads are registered, and same-cycle writes bypass to the read outputs. Register 0 can be hardwired to zero. After reset, a clear sequencer zeroes every entry, so no X state reaches the datapath. It sits between decode (rs1/rs2/rd) and the execute stage.

Parameters:
DATA_W, 32, data width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data is forwarded to a read of the same address
NUM_RD, 2, number of read ports (1 or 2); if 1, readOut2 is tied to 0

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
en  in  1  global enable; when 0, no write, no read-register update, clear sweep pauses
readEn  in  1  capture read data into readOut1/readOut2 this cycle
writeEn  in  1  write dataIn to entry rd this cycle
rd  in  ADDR_W  write address
rs1  in  ADDR_W  read address, port 1
rs2  in  ADDR_W  read address, port 2
dataIn  in  DATA_W  write data
readOut1  out  DATA_W  registered read data, port 1
readOut2  out  DATA_W  registered read data, port 2
busy  out  1  high while reset or the clear sweep is active; accesses are ignored

Behaviour:
- Synchronous active-high reset; clk is the only clock.
- When reset=1 at an edge:
  - readOut1 and readOut2 go to 0, and busy goes to 1.
  - The FSM goes to CLEAR and the clear pointer goes to 0.
  - Memory contents are not directly reset; the sweep zeroes them.
- FSM states:
  - CLEAR: each edge with en=1 writes 0 to mem[ptr] and sets ptr to ptr+1. When ptr=DEPTH-1 is written, the FSM goes to READY.
  - READY: normal operation. There is no exit except reset.
- Sweep timing and control:
  - The sweep takes exactly DEPTH enabled cycles after reset deasserts.
  - If en=0 during CLEAR, the sweep holds ptr.
  - Reset asserted mid-sweep restarts it at ptr=0.
- busy = (state==CLEAR) || reset. While busy=1:
  - writeEn and readEn are ignored.
  - readOut1 and readOut2 hold 0.
- Write (READY, en=1, writeEn=1): mem[rd] <= dataIn at the edge. If ZERO_REG=1 and rd=0, the write is dropped.
- Read (READY, en=1, readEn=1): readOutN <= value(rsN) at the edge, so data is valid one cycle after readEn is sampled. value(a) is defined as:
  - 0 if ZERO_REG=1 and a=0;
  - else dataIn if BYPASS=1, writeEn=1 and rd==a (write-first);
  - else mem[a] (the pre-write value when BYPASS=0).
- Read hold: if readEn=0 or en=0, readOutN holds its previous value.
- Both read ports may address the same entry, and both may match the write address. Each port resolves independently by the rule above.
- Bypass does not apply to a dropped write to entry 0.
- Address widths are exact: no wrap or out-of-range case exists. rd=DEPTH-1 is a valid top entry.
- NUM_RD=1: the rs2 input is unused and readOut2 is constant 0.
- The outputs never carry X after reset deasserts: sweep data is 0 and the outputs are forced to 0 while busy.

Test Plan:
- Reset and clear: hold reset 3 cycles, then release with en=1 -> busy=1 for exactly 32 cycles after release, then 0. All 32 entries then read 0x00000000. Assert reset at sweep cycle 10 -> busy stays high for 32 cycles after the new release.
- Write then read: write 0xDEADBEEF to rd=5; next cycle readEn=1, rs1=5, rs2=5 -> one edge later readOut1=readOut2=0xDEADBEEF. Set readEn=0, write 0x1 to rd=5 -> outputs hold 0xDEADBEEF.
- Bypass: mem[7]=0x11111111; same cycle writeEn=1, rd=7, dataIn=0x22222222, readEn=1, rs1=7, rs2=6 -> readOut1=0x22222222 and readOut2=mem[6]. With BYPASS=0 -> readOut1=0x11111111, and a later read returns 0x22222222.
- Zero register: write 0xFFFFFFFF to rd=0 with a same-cycle read of rs1=0 -> readOut1=0, and a later read is still 0. With ZERO_REG=0 -> a later read returns 0xFFFFFFFF.
- Enable gating and boundary: en=0 with writeEn=1, rd=31, dataIn=0xA5A5A5A5 -> no write. With en=1 -> entry 31 reads 0xA5A5A5A5. Pulse en low for 4 cycles mid-sweep -> busy lasts 32+4 cycles.
- Random regression (DATA_W=16, ADDR_W=3, NUM_RD=1): 1000 cycles of random en/readEn/writeEn/addresses/data compared cycle-by-cycle against a reference model. readOut2 must be 0 throughout.
